// File: rtl/first_counter_underflow.sv
// Loadable down-counter with sticky underflow flag, one-cycle borrow pulse on each
// wrap through zero, and optional auto-reload from the last loaded value.
module first_counter_underflow #(
  parameter int unsigned          WIDTH       = 4,
  parameter logic [WIDTH-1:0]     RELOAD_INIT = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             clear_flag,
  output logic [WIDTH-1:0] counter_out,
  output logic             underflow_out,
  output logic             borrow_pulse,
  output logic             zero_out
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             underflow_q, underflow_d;
  logic             borrow_q, borrow_d;
  logic             count_is_zero;

  assign count_is_zero = (counter_q == '0);

  always_comb begin
    counter_d   = counter_q;
    reload_d    = reload_q;
    borrow_d    = 1'b0;
    // A wrap on the same edge overrides the clear below, so set wins.
    underflow_d = underflow_q & ~clear_flag;
    if (load) begin
      counter_d = load_value;
      reload_d  = load_value;
    end else if (enable) begin
      if (count_is_zero) begin
        counter_d   = auto_reload ? reload_q : '1;
        borrow_d    = 1'b1;
        underflow_d = 1'b1;
      end else begin
        counter_d = counter_q - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q   <= '0;
      reload_q    <= RELOAD_INIT;
      underflow_q <= 1'b0;
      borrow_q    <= 1'b0;
    end else begin
      counter_q   <= counter_d;
      reload_q    <= reload_d;
      underflow_q <= underflow_d;
      borrow_q    <= borrow_d;
    end
  end

  assign counter_out   = counter_q;
  assign underflow_out = underflow_q;
  assign borrow_pulse  = borrow_q;
  assign zero_out      = count_is_zero;

endmodule

// File: tb/tb_first_counter_underflow.sv
// Directed bench for first_counter_underflow (WIDTH=4): one task per scenario,
// inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_first_counter_underflow;

  logic       clk = 1'b0;
  logic       reset, enable, load, auto_reload, clear_flag;
  logic [3:0] load_value;
  logic [3:0] counter_out;
  logic       underflow_out, borrow_pulse, zero_out;

  int errors = 0;
  int checks = 0;

  first_counter_underflow #(.WIDTH(4), .RELOAD_INIT(4'hF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .load_value(load_value), .auto_reload(auto_reload), .clear_flag(clear_flag),
    .counter_out(counter_out), .underflow_out(underflow_out),
    .borrow_pulse(borrow_pulse), .zero_out(zero_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [3:0] lv, input logic en,
                       input logic ar, input logic clr);
    load = ld; load_value = lv; enable = en; auto_reload = ar; clear_flag = clr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checks++; if (counter_out !== 4'd0) begin errors++; $display("FAIL reset_count: got %0h expected 0", counter_out); end
    checks++; if (underflow_out !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow_out); end
    checks++; if (borrow_pulse !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b expected 0", borrow_pulse); end
    checks++; if (zero_out !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", zero_out); end
    $display("test_reset done: count=%0h uf=%b borrow=%b zero=%b", counter_out, underflow_out, borrow_pulse, zero_out);
    reset = 1'b0;
  endtask

  task automatic test_auto_reload();
    logic [3:0] exp_seq [5] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd3};
    drive(1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        tick();
      end
      checks++; if (counter_out !== exp_seq[i]) begin errors++; $display("FAIL autoreload_count[%0d]: got %0h expected %0h", i, counter_out, exp_seq[i]); end
      checks++; if (borrow_pulse !== (i == 4)) begin errors++; $display("FAIL autoreload_borrow[%0d]: got %b expected %b", i, borrow_pulse, (i == 4)); end
      checks++; if (underflow_out !== (i == 4)) begin errors++; $display("FAIL autoreload_underflow[%0d]: got %b expected %b", i, underflow_out, (i == 4)); end
      checks++; if (zero_out !== (exp_seq[i] == 4'd0)) begin errors++; $display("FAIL autoreload_zero[%0d]: got %b", i, zero_out); end
      $display("test_auto_reload step %0d: count=%0h borrow=%b uf=%b", i, counter_out, borrow_pulse, underflow_out);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++; if (counter_out !== 4'd3) begin errors++; $display("FAIL idle_hold: got %0h expected 3", counter_out); end
    checks++; if (borrow_pulse !== 1'b0) begin errors++; $display("FAIL idle_borrow: got %b expected 0", borrow_pulse); end
    checks++; if (underflow_out !== 1'b1) begin errors++; $display("FAIL idle_sticky: got %b expected 1", underflow_out); end
    $display("test_auto_reload idle: count=%0h borrow=%b uf=%b", counter_out, borrow_pulse, underflow_out);
  endtask

  task automatic test_no_reload();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++; if (underflow_out !== 1'b0) begin errors++; $display("FAIL clear_alone: got %b expected 0", underflow_out); end
    checks++; if (counter_out !== 4'd3) begin errors++; $display("FAIL clear_keeps_count: got %0h expected 3", counter_out); end
    drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (counter_out !== 4'hF) begin errors++; $display("FAIL wrap_allones: got %0h expected f", counter_out); end
    checks++; if (borrow_pulse !== 1'b1) begin errors++; $display("FAIL wrap_borrow: got %b expected 1", borrow_pulse); end
    checks++; if (underflow_out !== 1'b1) begin errors++; $display("FAIL wrap_underflow: got %b expected 1", underflow_out); end
    tick();
    checks++; if (counter_out !== 4'hE) begin errors++; $display("FAIL after_wrap_count: got %0h expected e", counter_out); end
    checks++; if (borrow_pulse !== 1'b0) begin errors++; $display("FAIL after_wrap_borrow: got %b expected 0", borrow_pulse); end
    $display("test_no_reload: count=%0h borrow=%b uf=%b", counter_out, borrow_pulse, underflow_out);
  endtask

  task automatic test_clear_same_edge();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (underflow_out !== 1'b0) begin errors++; $display("FAIL pre_clear: got %b expected 0", underflow_out); end
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    tick();
    checks++; if (underflow_out !== 1'b1) begin errors++; $display("FAIL set_wins: got %b expected 1", underflow_out); end
    checks++; if (borrow_pulse !== 1'b1) begin errors++; $display("FAIL set_wins_borrow: got %b expected 1", borrow_pulse); end
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    checks++; if (underflow_out !== 1'b0) begin errors++; $display("FAIL later_clear: got %b expected 0", underflow_out); end
    checks++; if (counter_out !== 4'hF) begin errors++; $display("FAIL later_clear_count: got %0h expected f", counter_out); end
    $display("test_clear_same_edge: count=%0h uf=%b", counter_out, underflow_out);
  endtask

  task automatic test_load_priority();
    drive(1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (counter_out !== 4'd9) begin errors++; $display("FAIL load_over_enable: got %0h expected 9", counter_out); end
    checks++; if (borrow_pulse !== 1'b0) begin errors++; $display("FAIL load_borrow: got %b expected 0", borrow_pulse); end
    drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (counter_out !== 4'd0) begin errors++; $display("FAIL load_at_zero_count: got %0h expected 0", counter_out); end
    checks++; if (borrow_pulse !== 1'b0 || underflow_out !== 1'b0) begin errors++; $display("FAIL load_at_zero_nowrap: got borrow=%b uf=%b expected 0 0", borrow_pulse, underflow_out); end
    $display("test_load_priority: count=%0h borrow=%b uf=%b", counter_out, borrow_pulse, underflow_out);
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (counter_out !== 4'd5 || underflow_out !== 1'b1) begin errors++; $display("FAIL pre_reset: got count=%0h uf=%b expected 5 1", counter_out, underflow_out); end
    reset = 1'b1;
    drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    tick();
    reset = 1'b0;
    checks++; if (counter_out !== 4'd0) begin errors++; $display("FAIL midreset_count: got %0h expected 0", counter_out); end
    checks++; if (underflow_out !== 1'b0) begin errors++; $display("FAIL midreset_underflow: got %b expected 0", underflow_out); end
    tick();
    checks++; if (counter_out !== 4'hF) begin errors++; $display("FAIL midreset_reload: got %0h expected f", counter_out); end
    checks++; if (borrow_pulse !== 1'b1) begin errors++; $display("FAIL midreset_wrap_borrow: got %b expected 1", borrow_pulse); end
    $display("test_reset_mid: count=%0h borrow=%b uf=%b", counter_out, borrow_pulse, underflow_out);
  endtask

  task automatic test_back_to_back_wraps();
    drive(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (counter_out !== 4'd0) begin errors++; $display("FAIL b2b_count[%0d]: got %0h expected 0", i, counter_out); end
      checks++; if (borrow_pulse !== 1'b1) begin errors++; $display("FAIL b2b_borrow[%0d]: got %b expected 1", i, borrow_pulse); end
      $display("test_back_to_back step %0d: count=%0h borrow=%b", i, counter_out, borrow_pulse);
    end
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    tick();
    checks++; if (borrow_pulse !== 1'b0) begin errors++; $display("FAIL b2b_release: got %b expected 0", borrow_pulse); end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_auto_reload();
    test_no_reload();
    test_clear_same_edge();
    test_load_priority();
    test_reset_mid();
    test_back_to_back_wraps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
